// File: rtl/qnigma_chacha20_arb.sv
// Two-requester (TX/RX) arbiter in front of a single ChaCha20 block core.
// Round-robin grant, one-shot core launch, watchdog abort on a silent core.
module qnigma_chacha20_arb #(
    parameter int TMO_CYC = 1023,
    parameter int TMO_W   = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_i,
    input  logic [511:0] key_i,
    input  logic [191:0] non_i,
    input  logic [63:0]  ctr_i,
    output logic [1:0]   gnt_o,
    output logic [1:0]   val_o,
    output logic [511:0] kst_o,
    output logic [1:0]   err_o,
    output logic         cor_req,
    output logic [255:0] cor_key,
    output logic [95:0]  cor_non,
    output logic [31:0]  cor_bin,
    input  logic         cor_run,
    input  logic         cor_val,
    input  logic [511:0] cor_kst,
    output logic         busy_o
);

    // Handshake: req_i[n] is a level held until gnt_o[n] pulses; the parameters
    // are captured on that grant, and exactly one val_o[n] or err_o[n] pulse
    // closes the operation (unless rst abandons it).
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic             ptr;
    logic             owner;
    logic [TMO_W-1:0] wd;
    logic             take;
    logic             win;
    logic             tmo_hit;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        win       = 1'b0;
        tmo_hit   = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req_i && !cor_run) begin
                    take      = 1'b1;
                    win       = req_i[ptr] ? ptr : ~ptr;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: state_nxt = WAIT;
            WAIT: begin
                // A result arriving on the timeout cycle takes priority.
                if (cor_val) begin
                    state_nxt = IDLE;
                end else if (wd == TMO_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= 1'b0;
            owner   <= 1'b0;
            wd      <= '0;
            gnt_o   <= '0;
            val_o   <= '0;
            err_o   <= '0;
            cor_req <= 1'b0;
            kst_o   <= '0;
            cor_key <= '0;
            cor_non <= '0;
            cor_bin <= '0;
        end else begin
            gnt_o   <= '0;
            val_o   <= '0;
            err_o   <= '0;
            cor_req <= 1'b0;
            if (take) begin
                gnt_o   <= win ? 2'b10 : 2'b01;
                owner   <= win;
                ptr     <= ~win;
                cor_key <= win ? key_i[511:256] : key_i[255:0];
                cor_non <= win ? non_i[191:96]  : non_i[95:0];
                cor_bin <= win ? ctr_i[63:32]   : ctr_i[31:0];
            end
            if (state == LAUNCH) begin
                cor_req <= 1'b1;
                wd      <= '0;
            end
            if (state == WAIT) begin
                if (cor_val) begin
                    kst_o <= cor_kst;
                    val_o <= owner ? 2'b10 : 2'b01;
                end else if (tmo_hit) begin
                    err_o <= owner ? 2'b10 : 2'b01;
                end else begin
                    wd <= wd + TMO_W'(1);
                end
            end
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: doc/qnigma_chacha20_arb.md
QNIGMA_CHACHA20_ARB -- requirements
Module: qnigma_chacha20_arb

Interface
REQ-001 The block SHALL have parameter TMO_CYC, default 1023, giving the maximum cycles to wait for a keystream block before abort.
REQ-002 The block SHALL have parameter TMO_W, default 10, giving the watchdog counter width, with 2^TMO_W > TMO_CYC.
REQ-003 The block SHALL have ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_i  in  2  per-requester block request; index 0 is TX, 1 is RX; level, held until grant
- key_i  in  2x256  per-requester key
- non_i  in  2x96  per-requester nonce
- ctr_i  in  2x32  per-requester block counter
- gnt_o  out  2  one-cycle grant pulse; parameters latched
- val_o  out  2  one-cycle pulse; kst_o valid for that requester
- kst_o  out  512  keystream block, shared by both requesters
- err_o  out  2  one-cycle timeout pulse to the owning requester
- cor_req  out  1  core launch pulse
- cor_key  out  256  core key
- cor_non  out  96  core nonce
- cor_bin  out  32  core counter
- cor_run  in  1  core busy
- cor_val  in  1  core result pulse
- cor_kst  in  512  core result data
- busy_o  out  1  arbiter not IDLE

Function
REQ-004 The FSM SHALL have the states IDLE, LAUNCH and WAIT.
REQ-005 In IDLE with any req_i set and cor_run low, the block SHALL select a winner by round-robin pointer ptr.
- ptr names the preferred index.
- With only one requester active, that requester wins.
REQ-006 On selection the block SHALL:
- latch that requester's key/nonce/counter into cor_key/cor_non/cor_bin;
- pulse gnt_o[winner];
- record owner;
- set ptr to ~winner;
- go to LAUNCH.
REQ-007 In LAUNCH the block SHALL drive cor_req high for exactly one cycle, clear the watchdog, and go to WAIT.
REQ-008 cor_key, cor_non and cor_bin SHALL stay stable from grant until return to IDLE.
REQ-009 In WAIT, on cor_val the block SHALL register cor_kst into kst_o, pulse val_o[owner] the next cycle, and go to IDLE.
- Latency cor_val -> val_o is 1 cycle.
REQ-010 In WAIT the watchdog SHALL increment each cycle without cor_val.
- When it reaches TMO_CYC, the block SHALL pulse err_o[owner] and go to IDLE with no val_o.
- cor_val in the same cycle as the timeout SHALL win: deliver the result and raise no error.
REQ-011 cor_val outside WAIT SHALL be ignored: no val_o, kst_o unchanged.
REQ-012 A requester dropping req_i after its grant SHALL NOT cancel the operation.
- A requester still high after its val_o SHALL be re-arbitrated as a new request.
REQ-013 Minimum spacing between grants SHALL be 4 cycles: grant, LAUNCH, at least one WAIT cycle, return to IDLE.
REQ-014 If both requesters are continuously active, grants SHALL alternate 0,1,0,1.
REQ-015 busy_o SHALL be high in LAUNCH and WAIT.
REQ-016 At most one bit of gnt_o, val_o and err_o SHALL be high in any cycle.

Reset
REQ-017 The synchronous rst SHALL force:
- state IDLE, ptr=0, watchdog=0;
- gnt_o, val_o, err_o, cor_req, busy_o = 0;
- kst_o, cor_key, cor_non, cor_bin = 0.
REQ-018 rst during LAUNCH or WAIT SHALL abandon the operation silently; a later cor_val SHALL be ignored per REQ-011.

Verification
REQ-019 Single request: req_i=01, ctr_i[0]=1, core answers after 10 cycles with kst=A5..A5 -> the bench shall check:
- gnt_o=01 at cycle 0 and cor_req at cycle 1;
- cor_bin=1;
- val_o=01 with kst_o=A5..A5 one cycle after cor_val.
REQ-020 Both requesting from reset with constant req_i=11 -> grants 01,10,01,10; each val_o goes to its owner; no overlap.
REQ-021 Busy core: cor_run=1 with req_i=10 -> no grant until cor_run falls, then gnt_o=10 the next cycle.
REQ-022 Timeout with TMO_CYC=15 and no cor_val -> err_o=01 exactly 15 cycles after cor_req; then IDLE; a late cor_val produces no val_o.
REQ-023 Boundary: cor_val in the same cycle the watchdog hits TMO_CYC -> val_o pulses and err_o stays 0.
REQ-024 Reset in WAIT: assert rst, then pulse cor_val -> no val_o; busy_o=0; ptr=0, so next req_i=11 grants 01 first.
